// File: rtl/srio_tx_scheduler_if.sv
// rtl/srio_tx_scheduler_if.sv - source bank and master stream bundle for srio_tx_scheduler
interface srio_tx_scheduler_if #(
   parameter int NUM_SRC    = 4,
   parameter int DATA_WIDTH = 64
) ();
   logic [NUM_SRC-1:0]              src_ready_in;
   logic [NUM_SRC-1:0]              src_fetch_out;
   logic [NUM_SRC*DATA_WIDTH-1:0]   src_tdata_in;
   logic [NUM_SRC*DATA_WIDTH/8-1:0] src_tkeep_in;
   logic [NUM_SRC-1:0]              src_tvalid_in;
   logic [NUM_SRC-1:0]              src_tlast_in;
   logic [NUM_SRC-1:0]              src_tready_out;
   logic [DATA_WIDTH-1:0]           m_tdata;
   logic [DATA_WIDTH/8-1:0]         m_tkeep;
   logic                            m_tvalid;
   logic                            m_tlast;
   logic                            m_tready;

   modport master (
      input  src_ready_in, src_tdata_in, src_tkeep_in, src_tvalid_in, src_tlast_in, m_tready,
      output src_fetch_out, src_tready_out, m_tdata, m_tkeep, m_tvalid, m_tlast
   );

   modport slave (
      output src_ready_in, src_tdata_in, src_tkeep_in, src_tvalid_in, src_tlast_in, m_tready,
      input  src_fetch_out, src_tready_out, m_tdata, m_tkeep, m_tvalid, m_tlast
   );
endinterface

// File: rtl/srio_tx_scheduler.sv
// rtl/srio_tx_scheduler.sv - round-robin scheduler muxing buffered packet sources onto one SRIO TX stream
// Optional stall timeout with ABORT state and timeout_o: define SRIO_TX_SCHED_TIMEOUT_EN
module srio_tx_scheduler #(
   parameter int NUM_SRC        = 4,
   parameter int DATA_WIDTH     = 64,
   parameter int GRANT_WIDTH    = 2,
   parameter int BEAT_CNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   srio_tx_scheduler_if.master       bus,
   output logic [GRANT_WIDTH-1:0]    grant_o,
   output logic                      busy_o,
   output logic [BEAT_CNT_WIDTH-1:0] beat_cnt_o,
   output logic                      pkt_done_o
`ifdef SRIO_TX_SCHED_TIMEOUT_EN
   ,
   output logic                      timeout_o
`endif
);
   localparam int KEEP_WIDTH = DATA_WIDTH / 8;

`ifdef SRIO_TX_SCHED_TIMEOUT_EN
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_STREAM, S_DONE, S_ABORT} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_DONE} state_t;
`endif

   state_t                    r_state;
   state_t                    w_next;
   logic [GRANT_WIDTH-1:0]    r_grant;
   logic [GRANT_WIDTH-1:0]    r_last_grant;
   logic [BEAT_CNT_WIDTH-1:0] r_beat_cnt;
   logic [2*NUM_SRC-1:0]      w_ready_dbl;
   logic [NUM_SRC-1:0]        w_ready_rot;
   logic [GRANT_WIDTH-1:0]    w_sel;
   logic                      w_sel_vld;
   logic                      w_hs;
`ifdef SRIO_TX_SCHED_TIMEOUT_EN
   logic [15:0]               r_stall_cnt;
`endif

   // Rotating a doubled copy puts last_grant+1 at bit 0, so the first set bit wins.
   assign w_ready_dbl = {bus.src_ready_in, bus.src_ready_in};
   assign w_ready_rot = w_ready_dbl[int'(r_last_grant) + 1 +: NUM_SRC];

   always_comb begin
      w_sel     = '0;
      w_sel_vld = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (!w_sel_vld && w_ready_rot[k]) begin
            w_sel     = GRANT_WIDTH'((int'(r_last_grant) + 1 + k) % NUM_SRC);
            w_sel_vld = 1'b1;
         end
      end
   end

   always_comb begin
      bus.m_tdata        = '0;
      bus.m_tkeep        = '0;
      bus.m_tvalid       = 1'b0;
      bus.m_tlast        = 1'b0;
      bus.src_tready_out = '0;
      bus.src_fetch_out  = '0;
      if (r_state == S_STREAM) begin
         bus.m_tdata                 = bus.src_tdata_in[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
         bus.m_tkeep                 = bus.src_tkeep_in[int'(r_grant)*KEEP_WIDTH +: KEEP_WIDTH];
         bus.m_tvalid                = bus.src_tvalid_in[r_grant];
         bus.m_tlast                 = bus.src_tlast_in[r_grant];
         bus.src_tready_out[r_grant] = bus.m_tready;
      end
      if (r_state == S_FETCH) begin
         bus.src_fetch_out[r_grant] = 1'b1;
      end
   end

   assign w_hs = bus.m_tvalid & bus.m_tready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_sel_vld) w_next = S_FETCH;
         S_FETCH:  w_next = S_STREAM;
         S_STREAM: begin
            if (w_hs && bus.m_tlast) begin
               w_next = S_DONE;
            end
`ifdef SRIO_TX_SCHED_TIMEOUT_EN
            // The cycle that takes the stall count to all-ones is the one that aborts.
            else if (!w_hs && r_stall_cnt == 16'hFFFE) begin
               w_next = S_ABORT;
            end
`endif
         end
         S_DONE:   w_next = S_IDLE;
`ifdef SRIO_TX_SCHED_TIMEOUT_EN
         S_ABORT:  w_next = S_IDLE;
`endif
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_grant      <= '0;
         r_last_grant <= GRANT_WIDTH'(NUM_SRC - 1);
         r_beat_cnt   <= '0;
`ifdef SRIO_TX_SCHED_TIMEOUT_EN
         r_stall_cnt  <= '0;
`endif
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (w_sel_vld) r_grant <= w_sel;
            end
            S_FETCH: begin
               r_beat_cnt  <= '0;
`ifdef SRIO_TX_SCHED_TIMEOUT_EN
               r_stall_cnt <= '0;
`endif
            end
            S_STREAM: begin
               if (w_hs && r_beat_cnt != {BEAT_CNT_WIDTH{1'b1}}) begin
                  r_beat_cnt <= r_beat_cnt + BEAT_CNT_WIDTH'(1);
               end
`ifdef SRIO_TX_SCHED_TIMEOUT_EN
               r_stall_cnt <= w_hs ? 16'h0000 : r_stall_cnt + 16'h0001;
`endif
            end
            S_DONE: begin
               r_last_grant <= r_grant;
            end
`ifdef SRIO_TX_SCHED_TIMEOUT_EN
            S_ABORT: begin
               r_last_grant <= r_grant;
            end
`endif
            default: ;
         endcase
      end
   end

   assign grant_o    = r_grant;
   assign busy_o     = (r_state != S_IDLE);
   assign beat_cnt_o = r_beat_cnt;
   assign pkt_done_o = (r_state == S_DONE);
`ifdef SRIO_TX_SCHED_TIMEOUT_EN
   assign timeout_o  = (r_state == S_ABORT);
`endif
endmodule
